// File: rtl/dmem_pkg.sv
// Shared types and RV32I load/store size codes for the data-memory responder.
// Holds the FSM state enum, funct3 constants and the access-legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Illegal size code or an access that is not naturally aligned.
  function automatic logic access_err(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] lane
  );
    logic bad_f3;
    logic half;
    logic word;
    if (we)
      bad_f3 = !(f3 == SB || f3 == SH || f3 == SW);
    else
      bad_f3 = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    half = (f3[1:0] == 2'b01);
    word = (f3[1:0] == 2'b10);
    return bad_f3 || (half && lane[0]) || (word && lane != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store unit and the data memory.
// master = requester, slave = memory responder.
interface dmem_responder_if #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [2:0]               req_funct3;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ld_extend.sv
// Picks the addressed byte/half out of a memory word and sign/zero extends.
// Ports: i_word (aligned word), i_lane (addr[1:0]), i_funct3, o_data.
module ld_extend
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b = i_word[{i_lane, 3'b000} +: 8];
    w_h = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = '0;
    unique case (1'b1)
      (i_funct3 == LB):  o_data = {{24{w_b[7]}}, w_b};
      (i_funct3 == LH):  o_data = {{16{w_h[15]}}, w_h};
      (i_funct3 == LW):  o_data = i_word;
      (i_funct3 == LBU): o_data = {24'd0, w_b};
      (i_funct3 == LHU): o_data = {16'd0, w_h};
      default:           o_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Byte-addressed data memory with a fixed-latency valid/ready responder.
// Ports: clk, rst (async, active high), bus (slave side of dmem_responder_if).
module dmem_responder #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  import dmem_pkg::*;

  localparam int AW    = ADDRESS_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic [AW-1:0]         r_addr;
  logic [2:0]            r_f3;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [7:0]            r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_c_we;
  logic [AW-1:0]         w_c_addr;
  logic [2:0]            w_c_f3;
  logic [DATA_WIDTH-1:0] w_c_wdata;
  logic [AW-1:0]         w_base;
  logic [1:0]            w_lane;
  logic                  w_err;
  logic [31:0]           w_word;
  logic [31:0]           w_ld;
  logic [3:0]            w_be;
  logic [31:0]           w_wlane;

  assign w_accept = bus.req_valid && bus.req_ready;

  // With LATENCY 1 the commit edge is the accept edge, so the live bus
  // fields are used; otherwise the captured copies are.
  always_comb begin
    if (LATENCY == 1)
      w_commit = (r_state == IDLE) && w_accept;
    else
      w_commit = (r_state == WAIT) && (r_cnt == CW'(1));
  end

  always_comb begin
    w_c_we    = r_we;
    w_c_addr  = r_addr;
    w_c_f3    = r_f3;
    w_c_wdata = r_wdata;
    if (r_state == IDLE) begin
      w_c_we    = bus.req_we;
      w_c_addr  = bus.req_addr;
      w_c_f3    = bus.req_funct3;
      w_c_wdata = bus.req_wdata;
    end
  end

  assign w_lane = w_c_addr[1:0];
  assign w_base = {w_c_addr[AW-1:2], 2'b00};
  assign w_err  = access_err(w_c_we, w_c_f3, w_lane);

  always_comb begin
    w_word = '0;
    for (int k = 0; k < 4; k++)
      w_word[8*k +: 8] = r_mem[w_base + AW'(k)];
  end

  ld_extend u_ld_extend (
    .i_word   (w_word),
    .i_lane   (w_lane),
    .i_funct3 (w_c_f3),
    .o_data   (w_ld)
  );

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = w_c_wdata[31:0];
    unique case (1'b1)
      (w_c_f3 == SB): begin
        w_be    = 4'b0001 << w_lane;
        w_wlane = {4{w_c_wdata[7:0]}};
      end
      (w_c_f3 == SH): begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_c_wdata[15:0]}};
      end
      (w_c_f3 == SW): begin
        w_be    = 4'b1111;
        w_wlane = w_c_wdata[31:0];
      end
      default: w_be = 4'b0000;
    endcase
  end

  // Storage is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_commit && w_c_we && !w_err) begin
      for (int k = 0; k < 4; k++)
        if (w_be[k])
          r_mem[w_base + AW'(k)] <= w_wlane[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept)
              w_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (r_cnt == CW'(1)) w_next = RESP;
      RESP: if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (r_state == IDLE) && !rst;
    bus.rsp_valid = (r_state == RESP);
    bus.rsp_rdata = r_rdata;
    bus.rsp_err   = r_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_f3    <= '0;
      r_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CW'(LATENCY - 1);
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_f3    <= bus.req_funct3;
        r_wdata <= bus.req_wdata;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= w_err;
      r_rdata <= (w_err || w_c_we) ? '0 : DATA_WIDTH'(w_ld);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Covers LATENCY 2 (main DUT) and LATENCY 1 back-to-back traffic.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDRESS_WIDTH(9), .DATA_WIDTH(32)) bus0 ();
  dmem_responder_if #(.ADDRESS_WIDTH(9), .DATA_WIDTH(32)) bus1 ();

  dmem_responder #(
    .ADDRESS_WIDTH(9), .DATA_WIDTH(32), .LATENCY(LAT)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  dmem_responder #(
    .ADDRESS_WIDTH(9), .DATA_WIDTH(32), .LATENCY(1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [8:0] a,
                      input logic [2:0] f3, input logic [31:0] wd,
                      input int stall, output logic [31:0] rd,
                      output logic er);
    int lat;
    @(negedge clk);
    chk("req_ready_idle", 32'(bus0.req_ready), 32'd1);
    bus0.req_we     = we;
    bus0.req_addr   = a;
    bus0.req_funct3 = f3;
    bus0.req_wdata  = wd;
    bus0.req_valid  = 1'b1;
    bus0.rsp_ready  = 1'b0;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    lat = 1;
    while (!bus0.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT));
    rd = bus0.rsp_rdata;
    er = bus0.rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bus0.rsp_valid), 32'd1);
      chk("hold_rdata", bus0.rsp_rdata, rd);
      chk("hold_err", 32'(bus0.rsp_err), 32'(er));
      chk("hold_req_ready", 32'(bus0.req_ready), 32'd0);
    end
    bus0.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus0.rsp_ready = 1'b0;
    chk("rsp_dropped", 32'(bus0.rsp_valid), 32'd0);
    chk("ready_back", 32'(bus0.req_ready), 32'd1);
  endtask

  task automatic op(input string tag, input logic we,
                    input logic [8:0] a, input logic [2:0] f3,
                    input logic [31:0] wd, input int stall,
                    input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd;
    logic        er;
    xfer(we, a, f3, wd, stall, rd, er);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_err"}, 32'(er), 32'(exp_e));
  endtask

  typedef struct packed {
    logic        we;
    logic [8:0]  a;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t v1 [4];
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = '0;
    bus0.req_funct3 = '0; bus0.req_wdata = '0; bus0.rsp_ready = 0;
    bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = '0;
    bus1.req_funct3 = '0; bus1.req_wdata = '0; bus1.rsp_ready = 0;

    #12;
    chk("rst_req_ready", 32'(bus0.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("rst_rdata", bus0.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus0.rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_req_ready", 32'(bus0.req_ready), 32'd1);

    op("sw_010", 1, 9'h010, SW, 32'hDEADBEEF, 0, 32'h0, 0);
    op("lw_010", 0, 9'h010, LW, 32'h0, 0, 32'hDEADBEEF, 0);
    op("sb_013", 1, 9'h013, SB, 32'h00000080, 0, 32'h0, 0);
    op("lb_013", 0, 9'h013, LB, 32'h0, 0, 32'hFFFFFF80, 0);
    op("lbu_013", 0, 9'h013, LBU, 32'h0, 0, 32'h00000080, 0);
    op("lw_010b", 0, 9'h010, LW, 32'h0, 0, 32'h80ADBEEF, 0);
    op("sh_011", 1, 9'h011, SH, 32'h0000FFFF, 0, 32'h0, 1);
    op("lw_010c", 0, 9'h010, LW, 32'h0, 0, 32'h80ADBEEF, 0);
    op("lw_012", 0, 9'h012, LW, 32'h0, 0, 32'h0, 1);
    op("lh_012", 0, 9'h012, LH, 32'h0, 0, 32'hFFFF80AD, 0);
    op("lhu_012", 0, 9'h012, LHU, 32'h0, 0, 32'h000080AD, 0);
    op("lb_010", 0, 9'h010, LB, 32'h0, 0, 32'hFFFFFFEF, 0);
    op("lbu_011", 0, 9'h011, LBU, 32'h0, 0, 32'h000000BE, 0);
    op("ld_f3_011", 0, 9'h010, 3'b011, 32'h0, 0, 32'h0, 1);
    op("ld_f3_110", 0, 9'h010, 3'b110, 32'h0, 0, 32'h0, 1);
    op("st_f3_011", 1, 9'h010, 3'b011, 32'h11111111, 0, 32'h0, 1);
    op("sh_012", 1, 9'h012, SH, 32'hAAAA1234, 0, 32'h0, 0);
    op("lw_010d", 0, 9'h010, LW, 32'h0, 0, 32'h1234BEEF, 0);
    op("lw_stall", 0, 9'h010, LW, 32'h0, 5, 32'h1234BEEF, 0);

    op("sw_020", 1, 9'h020, SW, 32'hCAFEF00D, 0, 32'h0, 0);
    @(negedge clk);
    bus0.req_we = 1; bus0.req_addr = 9'h020;
    bus0.req_funct3 = SW; bus0.req_wdata = 32'h12345678;
    bus0.req_valid = 1;
    @(posedge clk);
    #1 bus0.req_valid = 0;
    #1 rst = 1'b1;
    #1;
    chk("rstw_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("rstw_req_ready", 32'(bus0.req_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_ready_rel", 32'(bus0.req_ready), 32'd1);
    chk("rstw_valid_rel", 32'(bus0.rsp_valid), 32'd0);
    chk("rstw_rdata_rel", bus0.rsp_rdata, 32'd0);
    op("lw_020", 0, 9'h020, LW, 32'h0, 0, 32'hCAFEF00D, 0);

    v1[0] = '{1'b1, 9'h040, SW, 32'h11223344, 32'h0};
    v1[1] = '{1'b0, 9'h040, LW, 32'h0, 32'h11223344};
    v1[2] = '{1'b1, 9'h044, SW, 32'hA5A5A5A5, 32'h0};
    v1[3] = '{1'b0, 9'h044, LW, 32'h0, 32'hA5A5A5A5};
    @(negedge clk);
    bus1.rsp_ready  = 1'b1;
    bus1.req_valid  = 1'b1;
    bus1.req_we     = v1[0].we;
    bus1.req_addr   = v1[0].a;
    bus1.req_funct3 = v1[0].f3;
    bus1.req_wdata  = v1[0].wd;
    for (int k = 0; k < 8; k++) begin
      int j;
      j = k / 2;
      if (k != 0) @(negedge clk);
      if (k % 2 == 0) begin
        chk("l1_req_ready", 32'(bus1.req_ready), 32'd1);
        chk("l1_rsp_idle", 32'(bus1.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        if (j < 3) begin
          bus1.req_we     = v1[j+1].we;
          bus1.req_addr   = v1[j+1].a;
          bus1.req_funct3 = v1[j+1].f3;
          bus1.req_wdata  = v1[j+1].wd;
        end else begin
          bus1.req_valid = 1'b0;
        end
      end else begin
        chk("l1_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
        chk("l1_req_busy", 32'(bus1.req_ready), 32'd0);
        chk("l1_rdata", bus1.rsp_rdata, v1[j].exp);
        chk("l1_err", 32'(bus1.rsp_err), 32'd0);
      end
    end
    @(negedge clk);
    chk("l1_final_idle", 32'(bus1.req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
